mem_tg_afu_csr: RTL and testbench
=================================

Name: mem_tg_afu_csr

Overview:
- Host-facing CSR responder for the memory traffic-generator AFU. Answers the register map the host test drives: DFH, AFU ID, scratch, TG control/status and the clocks perf counter.
- Converts host control writes into per-channel start pulses and tracks per-channel run state and pass/fail.
- Sits between the AFU's host MMIO bridge (64-bit Avalon-MM-style) and the NUM_TG traffic-generator channels.

Parameters:
NUM_TG, 4, number of traffic-generator channels (1..16)
ADDR_W, 16, byte-address width of the CSR port
AFU_DFH, 64'h1000010000001000, value returned at 0x00
AFU_ID_L, 64'hA3DC5B831F5CECBB, value returned at 0x08
AFU_ID_H, 64'h4DADEA342C7848CB, value returned at 0x10

Ports:
clk  in  1  CSR/AFU clock
rst_n  in  1  asynchronous active-low reset
avmm_address  in  ADDR_W  byte address; bits [2:0] ignored
avmm_read  in  1  read request
avmm_write  in  1  write request
avmm_writedata  in  64  write data
avmm_byteenable  in  8  write byte lanes
avmm_waitrequest  out  1  command not accepted this cycle
avmm_readdata  out  64  read data
avmm_readdatavalid  out  1  read data valid
tg_start  out  NUM_TG  one-cycle start pulse per channel
tg_test_complete  in  NUM_TG  level, channel finished (from TG)
tg_pass  in  NUM_TG  level, valid while complete
tg_fail  in  NUM_TG  level, valid while complete

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All state clears on rst_n low regardless of clk.
- Reset values: waitrequest=1 while rst_n low, 0 from the first clk after release; readdata=0; readdatavalid=0; tg_start=0; scratch=0; counter=0; all channels IDLE.
- Read handshake:
  - Command accepted when read=1 and waitrequest=0.
  - readdatavalid=1 with readdata exactly 1 cycle later.
  - waitrequest=1 in the cycle following an accepted read, so at most one read is outstanding.
  - readdata holds its last value when readdatavalid=0.
- Write handshake: accepted when write=1 and waitrequest=0; takes effect next edge.
- read and write asserted together: read serviced, write dropped.
- Map (decoded on address[ADDR_W-1:3]):
  - 0x00 AFU_DFH (RO)
  - 0x08 AFU_ID_L (RO)
  - 0x10 AFU_ID_H (RO)
  - 0x18 next-AFU, RO, reads 0
  - 0x20 reserved, RO, reads 0
  - 0x28 scratch, RW, per-byte byteenable
  - 0x30 TG_CTRL, write-1-to-start bits[NUM_TG-1:0], reads 0
  - 0x38 TG_STAT, RO
  - 0x50 clocks counter, RO
- Unmapped reads return 0. Writes to RO or unmapped addresses are ignored. No error response.
- TG_CTRL write: for each bit i set with byteenable covering it and channel i IDLE or DONE, tg_start[i]=1 in the cycle after the write edge, for exactly 1 cycle. Bits for channels in ARMED/RUN are ignored.
- Per-channel FSM:
  - IDLE -> ARMED on start pulse; latched pass/fail cleared.
  - ARMED -> RUN once tg_test_complete[i]=0, which rejects a stale complete from the previous run.
  - RUN -> DONE on tg_test_complete[i]=1; pass/fail sampled that cycle and latched.
  - DONE -> ARMED on a new start.
- TG_STAT nibble i at bits [4i+3:4i] = {0, fail_latched, pass_latched, active}, with active = ARMED|RUN. Unused upper bits read 0.
- Clocks counter:
  - 64-bit; +1 each clk while any channel is active.
  - Cleared to 0 on a start pulse issued while all channels are inactive.
  - Saturates at all-ones, no wrap.
  - A read returns the value as of the accept cycle.
- Reset mid-run: channels return to IDLE, an in-flight tg_start is killed, and a pending readdatavalid is dropped.

Test Plan:
- Reset release; read 0x00/0x08/0x10/0x18/0x40 -> 1000010000001000, A3DC5B831F5CECBB, 4DADEA342C7848CB, 0, 0; each with readdatavalid exactly 1 cycle after accept.
- Write 0x28=0x1122334455667788 be=0xFF, then 0xFFFF... be=0x0F; read -> 0x11223344FFFFFFFF. Back-to-back reads show waitrequest=1 on the second cycle.
- Write 0x30=0x2 (complete=0) -> tg_start=0x2 for one cycle; 0x38 reads 0x10. Repeat write while running -> no pulse.
- Raise tg_test_complete[1] with pass=1 after 100 active cycles -> 0x38 reads 0x20; 0x50 reads 100 ±1 and stays frozen after completion.
- Start ch0 while complete[0] is still high from a prior run -> stays ARMED (0x38 nibble0=1) until complete drops, then finishes only on the next rising complete.
- Pulse rst_n low mid-run and during an outstanding read -> no readdatavalid; 0x38=0, 0x50=0, tg_start=0.

Source files
------------

// File: rtl/mem_tg_afu_csr_if.sv
// Host MMIO bus (64-bit Avalon-MM style) between the AFU bridge and the TG CSR block.
interface mem_tg_afu_csr_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [63:0]       writedata;
    logic [7:0]        byteenable;
    logic              waitrequest;
    logic [63:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/mem_tg_afu_csr.sv
// CSR responder for the memory traffic-generator AFU: ID registers, scratch,
// per-channel start/status tracking and an active-clocks perf counter.
module mem_tg_afu_csr #(
    parameter int          NUM_TG   = 4,
    parameter int          ADDR_W   = 16,
    parameter logic [63:0] AFU_DFH  = 64'h1000010000001000,
    parameter logic [63:0] AFU_ID_L = 64'hA3DC5B831F5CECBB,
    parameter logic [63:0] AFU_ID_H = 64'h4DADEA342C7848CB
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_tg_afu_csr_if.slave   avmm,
    output logic [NUM_TG-1:0] tg_start,
    input  logic [NUM_TG-1:0] tg_test_complete,
    input  logic [NUM_TG-1:0] tg_pass,
    input  logic [NUM_TG-1:0] tg_fail
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } tg_state_t;

    localparam int AW = ADDR_W - 3;
    localparam logic [AW-1:0] W_DFH    = AW'(32'd0);
    localparam logic [AW-1:0] W_ID_L   = AW'(32'd1);
    localparam logic [AW-1:0] W_ID_H   = AW'(32'd2);
    localparam logic [AW-1:0] W_SCR    = AW'(32'd5);
    localparam logic [AW-1:0] W_CTRL   = AW'(32'd6);
    localparam logic [AW-1:0] W_STAT   = AW'(32'd7);
    localparam logic [AW-1:0] W_CLOCKS = AW'(32'd10);

    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  be);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    tg_state_t         state_r [NUM_TG];
    logic [NUM_TG-1:0] pass_r;
    logic [NUM_TG-1:0] fail_r;
    logic [NUM_TG-1:0] tg_start_r;
    logic              wait_r;
    logic              rdv_r;
    logic [63:0]       readdata_r;
    logic [63:0]       scratch_r;
    logic [63:0]       clocks_r;

    logic [AW-1:0]     word_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic [NUM_TG-1:0] start_req_s;
    logic [NUM_TG-1:0] active_s;
    logic [63:0]       stat_s;
    logic [63:0]       rd_mux_s;
    logic              unused_addr_s;

    assign word_s        = avmm.address[ADDR_W-1:3];
    assign unused_addr_s = ^avmm.address[2:0];
    // A read always wins over a simultaneous write.
    assign rd_acc_s      = avmm.read & ~wait_r;
    assign wr_acc_s      = avmm.write & ~avmm.read & ~wait_r;

    // Start requests: only idle or finished channels may be (re)launched.
    always_comb begin
        start_req_s = '0;
        active_s    = '0;
        for (int i = 0; i < NUM_TG; i++) begin
            active_s[i] = (state_r[i] == ST_ARMED) || (state_r[i] == ST_RUN);
            if (wr_acc_s && (word_s == W_CTRL) && avmm.writedata[i] &&
                avmm.byteenable[i/8] &&
                ((state_r[i] == ST_IDLE) || (state_r[i] == ST_DONE))) begin
                start_req_s[i] = 1'b1;
            end else begin
                start_req_s[i] = 1'b0;
            end
        end
    end

    // Status word and read-data mux.
    always_comb begin
        stat_s = 64'd0;
        for (int i = 0; i < NUM_TG; i++) begin
            stat_s[4*i +: 4] = {1'b0, fail_r[i], pass_r[i], active_s[i]};
        end
        case (word_s)
            W_DFH:    rd_mux_s = AFU_DFH;
            W_ID_L:   rd_mux_s = AFU_ID_L;
            W_ID_H:   rd_mux_s = AFU_ID_H;
            W_SCR:    rd_mux_s = scratch_r;
            W_STAT:   rd_mux_s = stat_s;
            W_CLOCKS: rd_mux_s = clocks_r;
            default:  rd_mux_s = 64'd0;
        endcase
    end

    // Bus handshake, read data, scratch and start pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_r     <= 1'b1;
            rdv_r      <= 1'b0;
            readdata_r <= 64'd0;
            scratch_r  <= 64'd0;
            tg_start_r <= '0;
        end else begin
            wait_r     <= rd_acc_s;
            rdv_r      <= rd_acc_s;
            tg_start_r <= start_req_s;
            if (rd_acc_s) begin
                readdata_r <= rd_mux_s;
            end
            if (wr_acc_s && (word_s == W_SCR)) begin
                scratch_r <= byte_merge(scratch_r, avmm.writedata, avmm.byteenable);
            end
        end
    end

    // Per-channel run FSM; ARMED waits for complete to drop so a stale
    // complete from the previous run is not mistaken for this one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TG; i++) begin
                state_r[i] <= ST_IDLE;
            end
            pass_r <= '0;
            fail_r <= '0;
        end else begin
            for (int i = 0; i < NUM_TG; i++) begin
                case (state_r[i])
                    ST_IDLE, ST_DONE: begin
                        if (start_req_s[i]) begin
                            state_r[i] <= ST_ARMED;
                            pass_r[i]  <= 1'b0;
                            fail_r[i]  <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (!tg_test_complete[i]) begin
                            state_r[i] <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (tg_test_complete[i]) begin
                            state_r[i] <= ST_DONE;
                            pass_r[i]  <= tg_pass[i];
                            fail_r[i]  <= tg_fail[i];
                        end
                    end
                    default: state_r[i] <= ST_IDLE;
                endcase
            end
        end
    end

    // Saturating active-clocks counter, restarted by a launch from all-idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clocks_r <= 64'd0;
        end else if ((|start_req_s) && !(|active_s)) begin
            clocks_r <= 64'd0;
        end else if ((|active_s) && (clocks_r != {64{1'b1}})) begin
            clocks_r <= clocks_r + 64'd1;
        end
    end

    assign avmm.waitrequest   = wait_r;
    assign avmm.readdatavalid = rdv_r;
    assign avmm.readdata      = readdata_r;
    assign tg_start           = tg_start_r;

endmodule

// File: tb/tb_mem_tg_afu_csr.sv
// Directed bench for mem_tg_afu_csr: ID map, scratch byte lanes, channel
// start/status flow, clocks counter and mid-run reset.
module tb_mem_tg_afu_csr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tg_start;
    logic [3:0] tg_test_complete = 4'd0;
    logic [3:0] tg_pass = 4'd0;
    logic [3:0] tg_fail = 4'd0;
    int         checks = 0;
    int         errors = 0;
    logic [63:0] rd;
    longint     t0;

    mem_tg_afu_csr_if #(.ADDR_W(16)) bus ();

    mem_tg_afu_csr dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .avmm             (bus),
        .tg_start         (tg_start),
        .tg_test_complete (tg_test_complete),
        .tg_pass          (tg_pass),
        .tg_fail          (tg_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.waitrequest !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {63'd0, bus.waitrequest}, 64'd0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
        wait_ready("wr");
        bus.address = a; bus.writedata = d; bus.byteenable = be; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input string tag, output logic [63:0] d);
        wait_ready(tag);
        bus.address = a; bus.read = 1'b1;
        @(negedge clk);
        check({tag, "_rdv"}, {63'd0, bus.readdatavalid}, 64'd1);
        check({tag, "_wait"}, {63'd0, bus.waitrequest}, 64'd1);
        d = bus.readdata;
        bus.read = 1'b0;
        @(negedge clk);
        check({tag, "_rdv_drop"}, {63'd0, bus.readdatavalid}, 64'd0);
        check({tag, "_hold"}, bus.readdata, d);
    endtask

    initial begin
        bus.address = 16'd0; bus.read = 1'b0; bus.write = 1'b0;
        bus.writedata = 64'd0; bus.byteenable = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wait", {63'd0, bus.waitrequest}, 64'd1);
        check("rst_rdv", {63'd0, bus.readdatavalid}, 64'd0);
        check("rst_rdata", bus.readdata, 64'd0);
        check("rst_start", {60'd0, tg_start}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_wait", {63'd0, bus.waitrequest}, 64'd0);

        // ID map and unmapped
        do_read(16'h0000, "dfh", rd);  check("dfh", rd, 64'h1000010000001000);
        do_read(16'h0008, "idl", rd);  check("idl", rd, 64'hA3DC5B831F5CECBB);
        do_read(16'h0010, "idh", rd);  check("idh", rd, 64'h4DADEA342C7848CB);
        do_read(16'h0018, "next", rd); check("next", rd, 64'd0);
        do_read(16'h0040, "unmap", rd); check("unmap", rd, 64'd0);
        do_write(16'h0000, 64'hDEADBEEFDEADBEEF, 8'hFF);
        do_read(16'h0000, "dfh_ro", rd); check("dfh_ro", rd, 64'h1000010000001000);

        // Scratch byte lanes
        do_write(16'h0028, 64'h1122334455667788, 8'hFF);
        do_write(16'h002C, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        do_read(16'h0028, "scr", rd); check("scr", rd, 64'h11223344FFFFFFFF);

        // Read and write together: write is dropped
        wait_ready("rw");
        bus.address = 16'h0028; bus.writedata = 64'd0; bus.byteenable = 8'hFF;
        bus.read = 1'b1; bus.write = 1'b1;
        @(negedge clk);
        check("rw_rdv", {63'd0, bus.readdatavalid}, 64'd1);
        check("rw_data", bus.readdata, 64'h11223344FFFFFFFF);
        bus.read = 1'b0; bus.write = 1'b0;
        @(negedge clk);
        do_read(16'h0028, "scr2", rd); check("scr2", rd, 64'h11223344FFFFFFFF);

        // Start channel 1
        do_write(16'h0030, 64'h2, 8'hFF);
        t0 = $time;
        check("start1", {60'd0, tg_start}, 64'h2);
        @(negedge clk);
        check("start1_end", {60'd0, tg_start}, 64'h0);
        do_read(16'h0038, "stat1", rd); check("stat1", rd, 64'h10);
        do_read(16'h0030, "ctrl_rd", rd); check("ctrl_rd", rd, 64'd0);
        do_write(16'h0030, 64'h2, 8'hFF);
        check("restart_ignored", {60'd0, tg_start}, 64'h0);

        // Complete after 100 active clocks
        while (($time - t0) < 990) @(negedge clk);
        tg_test_complete[1] = 1'b1; tg_pass[1] = 1'b1;
        @(negedge clk);
        do_read(16'h0038, "stat_done", rd); check("stat_done", rd, 64'h20);
        do_read(16'h0050, "clk_cnt", rd);   check("clk_cnt", rd, 64'd100);
        repeat (5) @(negedge clk);
        do_read(16'h0050, "clk_frozen", rd); check("clk_frozen", rd, 64'd100);

        // Channel 0 started while a stale complete is still high
        tg_test_complete[0] = 1'b1; tg_fail[0] = 1'b1;
        do_write(16'h0030, 64'h1, 8'hFF);
        check("start0", {60'd0, tg_start}, 64'h1);
        do_read(16'h0038, "armed", rd); check("armed", rd, 64'h21);
        repeat (3) @(negedge clk);
        do_read(16'h0038, "armed_hold", rd); check("armed_hold", rd, 64'h21);
        tg_test_complete[0] = 1'b0;
        repeat (2) @(negedge clk);
        do_read(16'h0038, "run0", rd); check("run0", rd, 64'h21);
        tg_test_complete[0] = 1'b1;
        repeat (2) @(negedge clk);
        do_read(16'h0038, "done0", rd); check("done0", rd, 64'h24);
        do_write(16'h0030, 64'h1, 8'hFE);
        check("be_masked", {60'd0, tg_start}, 64'h0);

        // Reset while a start pulse is in flight
        do_write(16'h0030, 64'h4, 8'hFF);
        check("start2", {60'd0, tg_start}, 64'h4);
        repeat (3) @(negedge clk);
        bus.address = 16'h0030; bus.writedata = 64'h8; bus.byteenable = 8'hFF; bus.write = 1'b1;
        @(posedge clk); #1;
        check("start3_inflight", {60'd0, tg_start}, 64'h8);
        rst_n = 1'b0; #1;
        check("start_killed", {60'd0, tg_start}, 64'h0);
        check("rst_wait2", {63'd0, bus.waitrequest}, 64'd1);
        bus.write = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        do_read(16'h0038, "stat_rst1", rd); check("stat_rst1", rd, 64'h0);

        // Reset during an outstanding read
        tg_test_complete = 4'd0;
        do_write(16'h0030, 64'h4, 8'hFF);
        repeat (4) @(negedge clk);
        bus.address = 16'h0050; bus.read = 1'b1;
        @(posedge clk); #1;
        check("rd_pending", {63'd0, bus.readdatavalid}, 64'd1);
        rst_n = 1'b0; #1;
        check("rdv_killed", {63'd0, bus.readdatavalid}, 64'd0);
        bus.read = 1'b0;
        @(negedge clk);
        check("rdv_in_rst", {63'd0, bus.readdatavalid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdv_after_rst", {63'd0, bus.readdatavalid}, 64'd0);
        do_read(16'h0038, "stat_rst2", rd); check("stat_rst2", rd, 64'h0);
        do_read(16'h0050, "clk_rst2", rd);  check("clk_rst2", rd, 64'h0);
        check("start_rst2", {60'd0, tg_start}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
